// File: rtl/apb_wait_slave_if.sv
// APB bus bundle for apb_wait_slave.
// master drives psel/penable/pwrite/paddr/pwdata; slave drives prdata/pready/pslverr.
interface apb_wait_slave_if;
  logic       psel;
  logic       penable;
  logic       pwrite;
  logic [7:0] paddr;
  logic [7:0] pwdata;
  logic [7:0] prdata;
  logic       pready;
  logic       pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_wait_slave.sv
// APB byte-storage slave with a fixed number of inserted wait states.
// Ports: pclk, presetn (async active-low), apb (slave modport: APB bus).
module apb_wait_slave #(
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic             pclk,
  input  logic             presetn,
  apb_wait_slave_if.slave  apb
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_READY
  } state_t;

  state_t          r_state;
  logic [3:0]      r_cnt;
  logic [AW-1:0]   r_addr;
  logic [7:0]      r_wdata;
  logic            r_write;
  logic            r_oor;
  logic [7:0]      r_prdata;
  logic            r_pready;
  logic            r_pslverr;
  logic [7:0]      r_mem [DEPTH];

  // range test on the full 8-bit address so DEPTH=256 never flags
  logic w_oor;
  assign w_oor = {1'b0, apb.paddr} >= 9'(DEPTH);

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_write   <= 1'b0;
      r_oor     <= 1'b0;
      r_prdata  <= '0;
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
      for (int i = 0; i < DEPTH; i++)
        r_mem[i] <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (apb.psel && !apb.penable) begin
            r_state <= S_WAIT;
            r_cnt   <= 4'(WAIT_CYCLES);
            r_addr  <= apb.paddr[AW-1:0];
            r_wdata <= apb.pwdata;
            r_write <= apb.pwrite;
            r_oor   <= w_oor;
          end
        end
        S_WAIT: begin
          if (!apb.psel) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end else if (r_cnt == '0) begin
            r_state   <= S_READY;
            r_pready  <= 1'b1;
            r_pslverr <= r_oor;
            if (!r_write)
              r_prdata <= r_oor ? 8'h00 : r_mem[r_addr];
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_READY: begin
          r_state   <= S_IDLE;
          r_pready  <= 1'b0;
          r_pslverr <= 1'b0;
          // a master that drops psel here abandons the write
          if (apb.psel && r_write && !r_oor)
            r_mem[r_addr] <= r_wdata;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign apb.prdata  = r_prdata;
  assign apb.pready  = r_pready;
  assign apb.pslverr = r_pslverr;

endmodule

// File: tb/tb_apb_wait_slave.sv
// Self-checking bench for apb_wait_slave: WAIT_CYCLES=2 and WAIT_CYCLES=0 instances.
// Directed table, hand-written corner sequences, then random traffic vs a model.
module tb_apb_wait_slave;

  localparam int DEPTH = 64;

  logic clk = 1'b0;
  logic rstn;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  apb_wait_slave_if b0 ();
  apb_wait_slave_if b1 ();

  apb_wait_slave #(.DEPTH(DEPTH), .WAIT_CYCLES(2)) u0 (
    .pclk    (clk),
    .presetn (rstn),
    .apb     (b0)
  );

  apb_wait_slave #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) u1 (
    .pclk    (clk),
    .presetn (rstn),
    .apb     (b1)
  );

  // reference state: storage contents and last read value per instance
  logic [7:0] mdl [2][256];
  logic [7:0] last_rd [2];

  typedef struct {
    int         w;
    bit         wr;
    logic [7:0] a;
    logic [7:0] d;
    logic [7:0] ed;
    bit         ee;
    bit         b2b;
  } vec_t;

  vec_t tbl [12];

  function automatic int wc(input int w);
    return (w == 0) ? 2 : 0;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drv(input int w, input bit s, input bit e, input bit wr,
                     input logic [7:0] a, input logic [7:0] d);
    if (w == 0) begin
      b0.psel = s; b0.penable = e; b0.pwrite = wr;
      b0.paddr = a; b0.pwdata = d;
    end else begin
      b1.psel = s; b1.penable = e; b1.pwrite = wr;
      b1.paddr = a; b1.pwdata = d;
    end
  endtask

  // {pready, pslverr, prdata}
  function automatic logic [9:0] obs(input int w);
    if (w == 0) return {b0.pready, b0.pslverr, b0.prdata};
    return {b1.pready, b1.pslverr, b1.prdata};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 256; i++) begin
      mdl[0][i] = 8'h00;
      mdl[1][i] = 8'h00;
    end
    last_rd[0] = 8'h00;
    last_rd[1] = 8'h00;
  endtask

  // One full transfer. Access-phase address/data/direction are scrambled
  // to show only the setup-phase values matter. Returns at the pready cycle.
  task automatic xfer(input int w, input bit wr, input logic [7:0] a,
                      input logic [7:0] d, input bit drop,
                      output logic [7:0] rd, output bit err,
                      output int t0);
    logic [9:0] o;
    int  low;
    bit  ok;
    bit  errlow;
    @(negedge clk);
    drv(1 - w, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    drv(w, 1'b1, 1'b0, wr, a, d);
    t0 = cyc;
    low = 0;
    ok = 1'b0;
    errlow = 1'b0;
    rd = 8'h00;
    err = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      o = obs(w);
      if (o[9]) begin
        ok = 1'b1;
        rd = o[7:0];
        err = o[8];
        if (drop) drv(w, 1'b0, 1'b0, wr, a, d);
        break;
      end
      low++;
      if (o[8]) errlow = 1'b1;
      drv(w, 1'b1, 1'b1, ~wr, 8'($urandom), 8'($urandom));
    end
    if (!ok) begin
      n_chk++;
      n_fail++;
      $display("FAIL pready_timeout: got no pready required pready within 40 cycles");
    end else begin
      chk("wait_len", low, wc(w) + 1);
      chk("pslverr_while_low", int'(errlow), 0);
    end
  endtask

  task automatic idle_all();
    @(negedge clk);
    drv(0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    drv(1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: got no finish required finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] rd;
    logic [9:0] o;
    bit         err;
    int         t0;
    int         prev_t0;
    bit         prev_b2b;
    int         w;
    bit         wr;
    bit         drop;
    logic [7:0] a;
    logic [7:0] d;
    bit         hi;

    tbl[0]  = '{0, 1'b1, 8'h10, 8'hA5, 8'h00, 1'b0, 1'b0};
    tbl[1]  = '{0, 1'b0, 8'h10, 8'h00, 8'hA5, 1'b0, 1'b0};
    tbl[2]  = '{0, 1'b1, 8'h40, 8'h3C, 8'h00, 1'b1, 1'b0};
    tbl[3]  = '{0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
    tbl[4]  = '{0, 1'b0, 8'h40, 8'h00, 8'h00, 1'b1, 1'b0};
    tbl[5]  = '{0, 1'b1, 8'h00, 8'h01, 8'h00, 1'b0, 1'b1};
    tbl[6]  = '{0, 1'b1, 8'h3F, 8'h02, 8'h00, 1'b0, 1'b1};
    tbl[7]  = '{0, 1'b0, 8'h00, 8'h00, 8'h01, 1'b0, 1'b1};
    tbl[8]  = '{0, 1'b0, 8'h3F, 8'h00, 8'h02, 1'b0, 1'b1};
    tbl[9]  = '{1, 1'b1, 8'h22, 8'h5A, 8'h00, 1'b0, 1'b0};
    tbl[10] = '{1, 1'b0, 8'h22, 8'h00, 8'h5A, 1'b0, 1'b0};
    tbl[11] = '{1, 1'b0, 8'h50, 8'h00, 8'h00, 1'b1, 1'b0};

    rstn = 1'b0;
    drv(0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    drv(1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    model_reset();
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      o = obs(i);
      chk("rst_pready", int'(o[9]), 0);
      chk("rst_pslverr", int'(o[8]), 0);
      chk("rst_prdata", int'(o[7:0]), 0);
    end
    rstn = 1'b1;

    // directed table, all transfers back-to-back
    prev_t0 = 0;
    prev_b2b = 1'b0;
    for (int i = 0; i < 12; i++) begin
      xfer(tbl[i].w, tbl[i].wr, tbl[i].a, tbl[i].d, 1'b0, rd, err, t0);
      chk($sformatf("tbl%0d_err", i), int'(err), int'(tbl[i].ee));
      if (!tbl[i].wr) begin
        chk($sformatf("tbl%0d_rdata", i), int'(rd), int'(tbl[i].ed));
        last_rd[tbl[i].w] = tbl[i].ed;
      end else if (tbl[i].a < DEPTH) begin
        mdl[tbl[i].w][tbl[i].a] = tbl[i].d;
      end
      if (tbl[i].b2b && prev_b2b)
        chk($sformatf("tbl%0d_period", i), t0 - prev_t0, wc(tbl[i].w) + 3);
      prev_t0 = t0;
      prev_b2b = tbl[i].b2b;
    end
    idle_all();

    // psel dropped in the pready cycle: no write, no error
    xfer(0, 1'b1, 8'h07, 8'h99, 1'b1, rd, err, t0);
    chk("drop_ready_err", int'(err), 0);
    idle_all();
    xfer(0, 1'b0, 8'h07, 8'h00, 1'b0, rd, err, t0);
    chk("drop_ready_rdata", int'(rd), 0);
    last_rd[0] = 8'h00;
    idle_all();

    // psel dropped in the second access cycle: transfer abandoned
    @(negedge clk);
    drv(0, 1'b1, 1'b0, 1'b1, 8'h05, 8'h77);
    hi = 1'b0;
    @(negedge clk);
    hi = hi | b0.pready;
    drv(0, 1'b1, 1'b1, 1'b1, 8'h05, 8'h77);
    @(negedge clk);
    hi = hi | b0.pready;
    drv(0, 1'b0, 1'b0, 1'b1, 8'h05, 8'h77);
    repeat (4) begin
      @(negedge clk);
      hi = hi | b0.pready;
    end
    chk("abort_pready", int'(hi), 0);
    xfer(0, 1'b0, 8'h05, 8'h00, 1'b0, rd, err, t0);
    chk("abort_rdata", int'(rd), 0);
    chk("abort_err", int'(err), 0);
    idle_all();

    // make prdata nonzero, then reset in the middle of a write's wait
    xfer(0, 1'b0, 8'h10, 8'h00, 1'b0, rd, err, t0);
    chk("pre_rst_rdata", int'(rd), 8'hA5);
    idle_all();
    @(negedge clk);
    drv(0, 1'b1, 1'b0, 1'b1, 8'h20, 8'h11);
    @(negedge clk);
    drv(0, 1'b1, 1'b1, 1'b1, 8'h20, 8'h11);
    @(negedge clk);
    #2 rstn = 1'b0;
    #1 o = obs(0);
    chk("midrst_pready", int'(o[9]), 0);
    chk("midrst_pslverr", int'(o[8]), 0);
    chk("midrst_prdata", int'(o[7:0]), 0);
    drv(0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    model_reset();
    @(negedge clk);
    rstn = 1'b1;
    xfer(0, 1'b0, 8'h20, 8'h00, 1'b0, rd, err, t0);
    chk("postrst_rdata", int'(rd), 0);
    chk("postrst_err", int'(err), 0);
    xfer(0, 1'b0, 8'h10, 8'h00, 1'b0, rd, err, t0);
    chk("postrst_clear", int'(rd), 0);
    idle_all();

    // random traffic against the model
    for (int i = 0; i < 150; i++) begin
      w = int'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      a = 8'($urandom_range(0, 79));
      d = 8'($urandom);
      drop = (a < DEPTH) && ($urandom_range(0, 7) == 0);
      xfer(w, wr, a, d, drop, rd, err, t0);
      chk("rnd_err", int'(err), (a >= DEPTH) ? 1 : 0);
      if (!wr) begin
        last_rd[w] = (a < DEPTH) ? mdl[w][a] : 8'h00;
      end else if (a < DEPTH && !drop) begin
        mdl[w][a] = d;
      end
      chk("rnd_rdata", int'(rd), int'(last_rd[w]));
      if ($urandom_range(0, 3) == 0) idle_all();
    end
    idle_all();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_wait_slave.md
APB_WAIT_SLAVE -- requirements
Module: apb_wait_slave

Interface
REQ-001 Parameter DEPTH, 64, number of 8-bit storage locations, addresses 0..DEPTH-1 (DEPTH <= 256).
REQ-002 Parameter WAIT_CYCLES, 2, extra pready-low access cycles inserted per transfer (0..15).
REQ-003 pclk  input  1  single clock; all state updates on the rising edge.
REQ-004 presetn  input  1  reset, asynchronous assert, active-low.
REQ-005 psel  input  1  slave select from the APB master.
REQ-006 penable  input  1  access-phase indicator from the master.
REQ-007 pwrite  input  1  1 = write, 0 = read.
REQ-008 paddr  input  8  byte address.
REQ-009 pwdata  input  8  write data.
REQ-010 prdata  output  8  read data, registered.
REQ-011 pready  output  1  transfer-complete indicator, registered.
REQ-012 pslverr  output  1  error response, registered, valid only while pready=1.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, WAIT, READY.
REQ-014 IDLE: on psel=1 and penable=0 (setup phase), the FSM SHALL go to WAIT and load the wait counter with WAIT_CYCLES; otherwise it stays in IDLE.
REQ-015 WAIT: psel=0 SHALL return to IDLE with no storage update; counter=0 SHALL go to READY; otherwise the counter decrements.
REQ-016 READY: the FSM SHALL always return to IDLE on the next edge; a new setup phase is recognised only from IDLE.
REQ-017 pready SHALL be 1 only while in READY; per transfer it is low for exactly WAIT_CYCLES+1 access cycles, then high for exactly one cycle.
REQ-018 paddr, pwrite and pwdata SHALL be captured on the IDLE->WAIT edge; later changes during the transfer are ignored.
REQ-019 In-range write (captured addr < DEPTH): storage[addr] SHALL be updated with captured pwdata on the READY->IDLE edge, and only if psel=1 in READY.
REQ-020 In-range read: prdata SHALL be loaded with storage[addr] on the WAIT->READY edge.
REQ-021 Out-of-range access (addr >= DEPTH): pslverr SHALL be 1 during READY; writes SHALL NOT modify storage; reads SHALL drive prdata=0x00.
REQ-022 pslverr SHALL be 0 in every state except READY.
REQ-023 prdata SHALL hold its last loaded value at all other times.
REQ-024 Back-to-back transfers SHALL be supported: one IDLE cycle (the next setup phase) follows READY, giving WAIT_CYCLES+3 cycles per transfer.
REQ-025 A read of an address written in the immediately preceding transfer SHALL return the new data.
REQ-026 psel=0 in READY SHALL complete the handshake without a storage write and with no error.

Reset
REQ-027 presetn=0 SHALL immediately force: state IDLE, counter 0, pready 0, pslverr 0, prdata 0x00, all storage 0x00, captured registers 0.
REQ-028 Reset asserted mid-transfer SHALL abort it with no storage write; after release the block waits in IDLE for a new setup phase.

Verification
REQ-029 WAIT_CYCLES=2: write 0xA5 to 0x10, then read 0x10 -> pready low 3 access cycles then high 1 cycle each time; read prdata=0xA5, pslverr=0.
REQ-030 Write 0x3C to 0x40 (DEPTH=64) -> pslverr=1 with pready; a following read of 0x00 returns 0x00, confirming no aliasing; a read of 0x40 returns 0x00 with pslverr=1.
REQ-031 Setup for a write of 0x77 to 0x05, then drop psel in the second access cycle -> FSM back to IDLE, pready never high; read 0x05 returns 0x00.
REQ-032 Assert presetn=0 during WAIT of a write of 0x11 to 0x20 -> pready, pslverr, prdata go 0 immediately; after release, read 0x20 returns 0x00.
REQ-033 Back-to-back writes 0x01->0x00, 0x02->0x3F, then reads -> 0x01, 0x02; each transfer takes exactly WAIT_CYCLES+3 cycles, setup to setup.
REQ-034 WAIT_CYCLES=0: any read or write -> pready high in the second access cycle (1 low cycle), data correct.
